// File: rtl/serial_magnitude_comparator_if.sv
// Start/busy/done compare bus: the requester drives operands and start, the comparator returns status and result.
interface serial_magnitude_comparator_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, gt, eq, lt
  );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// Multi-cycle MSB-first magnitude comparator, DIGIT bits per cycle, with early exit on the first differing digit.
module serial_magnitude_comparator #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  serial_magnitude_comparator_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int KW   = $clog2(NDIG);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [KW-1:0]    k, k_n;
  logic [WIDTH-1:0] a_p0, b_p0, a_n, b_n;
  logic             fin_p1, fin_n;
  logic             gt_p1, gt_n;
  logic             eq_p1, eq_n;
  logic             busy_p2, done_p2, gt_p2, eq_p2, lt_p2;
  logic [DIGIT-1:0] da, db;
  logic [WIDTH-1:0] sign_flip;
  logic             accept;

  // Operands shift left after each equal digit, so the current digit is always on top.
  assign da        = a_p0[WIDTH-1 -: DIGIT];
  assign db        = b_p0[WIDTH-1 -: DIGIT];
  assign sign_flip = {bus.signed_mode, {(WIDTH-1){1'b0}}};
  // busy_p2 lags state by a cycle, so it also blocks the cycle right after the decision.
  assign accept    = bus.start && (state == IDLE) && !busy_p2;

  always_comb begin
    state_n = state;
    k_n     = k;
    a_n     = a_p0;
    b_n     = b_p0;
    fin_n   = 1'b0;
    gt_n    = gt_p1;
    eq_n    = eq_p1;
    case (state)
      IDLE: begin
        if (accept) begin
          a_n     = bus.a ^ sign_flip;
          b_n     = bus.b ^ sign_flip;
          k_n     = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (da != db) begin
          fin_n   = 1'b1;
          gt_n    = (da > db);
          eq_n    = 1'b0;
          state_n = IDLE;
        end else if (k == KW'(NDIG - 1)) begin
          fin_n   = 1'b1;
          gt_n    = 1'b0;
          eq_n    = 1'b1;
          state_n = IDLE;
        end else begin
          k_n = k + KW'(1);
          a_n = a_p0 << DIGIT;
          b_n = b_p0 << DIGIT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      k       <= '0;
      a_p0    <= '0;
      b_p0    <= '0;
      fin_p1  <= 1'b0;
      gt_p1   <= 1'b0;
      eq_p1   <= 1'b0;
      busy_p2 <= 1'b0;
      done_p2 <= 1'b0;
      gt_p2   <= 1'b0;
      eq_p2   <= 1'b0;
      lt_p2   <= 1'b0;
    end else begin
      // stage 0/1: operand capture, digit walk and decision
      state  <= state_n;
      k      <= k_n;
      a_p0   <= a_n;
      b_p0   <= b_n;
      fin_p1 <= fin_n;
      gt_p1  <= gt_n;
      eq_p1  <= eq_n;
      // stage 2: registered status and sticky result
      busy_p2 <= (state == RUN);
      done_p2 <= fin_p1;
      if (fin_p1) begin
        gt_p2 <= gt_p1;
        eq_p2 <= eq_p1;
        lt_p2 <= ~gt_p1 & ~eq_p1;
      end
    end
  end

  assign bus.busy = busy_p2;
  assign bus.done = done_p2;
  assign bus.gt   = gt_p2;
  assign bus.eq   = eq_p2;
  assign bus.lt   = lt_p2;
endmodule
